multilane_serializer: RTL and testbench

- Parametrised successor to the single-lane, one-shot serializer.
- Accepts MSG_SIZE-bit frames over a valid/ready load handshake and emits each one as MSG_SIZE/LANES beats of LANES bits. Bit order is selectable: MSB-first or LSB-first.
- A one-entry pending buffer allows back-to-back frames with zero idle cycles. The block re-arms automatically, so there is no done-latch.
- Sits between the message/cipher datapath and the output pins.

---
 rtl/multilane_serializer.sv | 135 +++++++++++++
 tb/tb_multilane_serializer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multilane_serializer.sv
// Multi-lane frame serializer: accepts MSG_SIZE-bit frames over a valid/ready
// handshake and streams them out LANES bits per beat, with a one-frame pending buffer.
module multilane_serializer #(
    parameter int MSG_SIZE  = 64,
    parameter int LANES     = 1,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [MSG_SIZE-1:0] iData_in,
    input  logic                iLoad,
    output logic                oReady,
    output logic [LANES-1:0]    oData_out,
    output logic                oData_flag,
    output logic                oLast
);

    localparam int BEATS = MSG_SIZE / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

    generate
        if (MSG_SIZE % LANES != 0) begin : g_bad_lanes
            $error("multilane_serializer: LANES must divide MSG_SIZE");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [MSG_SIZE-1:0] shreg_q, shreg_d;
    logic [MSG_SIZE-1:0] pend_q, pend_d;
    logic                pend_v_q, pend_v_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       cnt_inc;
    logic [LANES-1:0]    out_d;
    logic                flag_d, last_d;
    logic                accept, load_en;
    logic [MSG_SIZE-1:0] load_src;

    function automatic logic [LANES-1:0] first_beat(input logic [MSG_SIZE-1:0] f);
        if (LSB_FIRST) return f[LANES-1:0];
        else           return f[MSG_SIZE-1 -: LANES];
    endfunction

    function automatic logic [MSG_SIZE-1:0] drop_beat(input logic [MSG_SIZE-1:0] f);
        if (LSB_FIRST) return f >> LANES;
        else           return f << LANES;
    endfunction

    assign oReady  = ena && !pend_v_q && rst_n;
    assign accept  = iLoad && oReady;
    assign cnt_inc = cnt_q + CW'(1);

    // The shifter always holds the beats not yet shown, so the next beat is its head.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        cnt_d    = cnt_q;
        out_d    = oData_out;
        flag_d   = oData_flag;
        last_d   = oLast;
        load_en  = 1'b0;
        load_src = iData_in;

        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) load_en = 1'b1;
                end
                SHIFT: begin
                    if (oLast) begin
                        if (pend_v_q) begin
                            load_en  = 1'b1;
                            load_src = pend_q;
                            pend_v_d = 1'b0;
                        end else if (accept) begin
                            load_en = 1'b1;
                        end else begin
                            state_d = IDLE;
                            out_d   = '0;
                            flag_d  = 1'b0;
                            last_d  = 1'b0;
                            cnt_d   = '0;
                        end
                    end else begin
                        out_d   = first_beat(shreg_q);
                        shreg_d = drop_beat(shreg_q);
                        cnt_d   = cnt_inc;
                        last_d  = (cnt_inc == LAST_IDX);
                        if (accept) begin
                            pend_d   = iData_in;
                            pend_v_d = 1'b1;
                        end
                    end
                end
            endcase

            if (load_en) begin
                state_d = SHIFT;
                out_d   = first_beat(load_src);
                shreg_d = drop_beat(load_src);
                cnt_d   = '0;
                last_d  = (BEATS == 1);
                flag_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            cnt_q      <= '0;
            oData_out  <= '0;
            oData_flag <= 1'b0;
            oLast      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            cnt_q      <= cnt_d;
            oData_out  <= out_d;
            oData_flag <= flag_d;
            oLast      <= last_d;
        end
    end

endmodule

// File: tb/tb_multilane_serializer.sv
// Testbench for multilane_serializer: three configurations, directed scenarios
// plus a randomized run against a frame-level reference model.
module tb_multilane_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena;

    // Instance A: 16-bit frames, 4 lanes, MSB-first (model-tracked)
    logic        a_load, a_ready, a_flag, a_last;
    logic [15:0] a_data;
    logic [3:0]  a_out;
    // Instance B: 16-bit frames, 4 lanes, LSB-first
    logic        b_load, b_ready, b_flag, b_last;
    logic [15:0] b_data;
    logic [3:0]  b_out;
    // Instance C: 64-bit frames, 1 lane, MSB-first
    logic        c_load, c_ready, c_flag, c_last;
    logic [63:0] c_data;
    logic [0:0]  c_out;

    int checks = 0;
    int errors = 0;

    multilane_serializer #(.MSG_SIZE(16), .LANES(4), .LSB_FIRST(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .iData_in(a_data), .iLoad(a_load),
        .oReady(a_ready), .oData_out(a_out), .oData_flag(a_flag), .oLast(a_last));

    multilane_serializer #(.MSG_SIZE(16), .LANES(4), .LSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .iData_in(b_data), .iLoad(b_load),
        .oReady(b_ready), .oData_out(b_out), .oData_flag(b_flag), .oLast(b_last));

    multilane_serializer #(.MSG_SIZE(64), .LANES(1), .LSB_FIRST(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .iData_in(c_data), .iLoad(c_load),
        .oReady(c_ready), .oData_out(c_out), .oData_flag(c_flag), .oLast(c_last));

    // Frame-level model of instance A: the frame on the wire, which beat of it is shown, and the queued frame
    bit          m_active;
    logic [15:0] m_frame;
    int          m_idx;
    bit          m_pend_v;
    logic [15:0] m_pend;

    function automatic logic [3:0] msb_beat(input logic [15:0] f, input int i);
        logic [15:0] t;
        t = f >> (12 - 4 * i);
        return t[3:0];
    endfunction

    task automatic model_reset();
        m_active = 0; m_frame = '0; m_idx = 0; m_pend_v = 0; m_pend = '0;
    endtask

    task automatic model_step(input logic load, input logic [15:0] data, input logic en);
        bit acc;
        acc = load && en && !m_pend_v;
        if (!en) return;
        if (!m_active) begin
            if (acc) begin m_active = 1; m_frame = data; m_idx = 0; end
        end else if (m_idx == 3) begin
            if (m_pend_v) begin m_frame = m_pend; m_idx = 0; m_pend_v = 0; end
            else if (acc) begin m_frame = data; m_idx = 0; end
            else m_active = 0;
        end else begin
            m_idx++;
            if (acc) begin m_pend = data; m_pend_v = 1; end
        end
    endtask

    task automatic step_a(input logic load, input logic [15:0] data, input logic en);
        @(negedge clk);
        a_load = load; a_data = data; ena = en;
        @(posedge clk);
        model_step(load, data, en);
        #1;
    endtask

    task automatic tick_b(input logic load, input logic [15:0] data);
        @(negedge clk);
        b_load = load; b_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_c(input logic load, input logic [63:0] data);
        @(negedge clk);
        c_load = load; c_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        a_load = 1'b0; b_load = 1'b0; c_load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b1;
        a_load = 1'b1; a_data = 16'hFFFF;
        b_load = 1'b1; b_data = 16'hFFFF;
        c_load = 1'b1; c_data = '1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (a_flag !== 1'b0 || a_last !== 1'b0 || a_out !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_a: flag=%b last=%b out=%h, required 0 0 0", a_flag, a_last, a_out);
        end
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready_low: oReady=%b, required 0", a_ready);
        end
        checks++;
        if (b_flag !== 1'b0 || c_flag !== 1'b0 || b_out !== 4'h0 || c_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_bc: b_flag=%b c_flag=%b b_out=%h c_out=%b, required all 0", b_flag, c_flag, b_out, c_out);
        end
        @(negedge clk);
        rst_n = 1'b1; a_load = 1'b0; b_load = 1'b0; c_load = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1 || c_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: a=%b b=%b c=%b, required 1 1 1", a_ready, b_ready, c_ready);
        end
    endtask

    task automatic test_wide_single_lane();
        logic [63:0] frame;
        frame = 64'h8000_0000_0000_0001;
        tick_c(1'b1, frame);
        checks++;
        if (c_out !== 1'b1 || c_flag !== 1'b1 || c_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wide_beat0: out=%b flag=%b last=%b, required 1 1 0", c_out, c_flag, c_last);
        end
        for (int i = 1; i < 64; i++) begin
            tick_c(1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
            checks++;
            if (c_out !== frame[63 - i] || c_flag !== 1'b1 || c_last !== (i == 63)) begin
                errors++;
                $display("[TB] FAIL wide_beat%0d: out=%b flag=%b last=%b, required %b 1 %b",
                         i, c_out, c_flag, c_last, frame[63 - i], (i == 63));
            end
        end
        tick_c(1'b0, '0);
        checks++;
        if (c_flag !== 1'b0 || c_ready !== 1'b1 || c_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wide_end: flag=%b ready=%b last=%b, required 0 1 0", c_flag, c_ready, c_last);
        end
    endtask

    task automatic test_lsb_lanes();
        logic [3:0] exp_beats [4];
        exp_beats = '{4'h3, 4'hC, 4'h5, 4'hA};
        for (int i = 0; i < 4; i++) begin
            tick_b(i == 0, (i == 0) ? 16'hA5C3 : 16'h0000);
            checks++;
            if (b_out !== exp_beats[i] || b_flag !== 1'b1 || b_last !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL lsb_beat%0d: out=%h flag=%b last=%b, required %h 1 %b",
                         i, b_out, b_flag, b_last, exp_beats[i], (i == 3));
            end
        end
        tick_b(1'b0, 16'h0000);
        checks++;
        if (b_flag !== 1'b0 || b_out !== 4'h0) begin
            errors++;
            $display("[TB] FAIL lsb_end: flag=%b out=%h, required 0 0", b_flag, b_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_out [8];
        bit         exp_rdy [8];
        exp_out = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
        exp_rdy = '{1, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            step_a(i < 2, (i == 0) ? 16'h1234 : 16'hABCD, 1'b1);
            checks++;
            if (a_out !== exp_out[i] || a_flag !== 1'b1 || a_last !== (i == 3 || i == 7) || a_ready !== exp_rdy[i]) begin
                errors++;
                $display("[TB] FAIL b2b_beat%0d: out=%h flag=%b last=%b ready=%b, required %h 1 %b %b",
                         i, a_out, a_flag, a_last, a_ready, exp_out[i], (i == 3 || i == 7), exp_rdy[i]);
            end
        end
        step_a(1'b0, 16'h0000, 1'b1);
        checks++;
        if (a_flag !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_end: flag=%b ready=%b, required 0 1", a_flag, a_ready);
        end
    endtask

    task automatic test_ena_hold();
        step_a(1'b1, 16'h1234, 1'b1);
        step_a(1'b0, 16'h0000, 1'b1);
        step_a(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 16'h7777, 1'b0);
            checks++;
            if (a_out !== 4'h3 || a_flag !== 1'b1 || a_last !== 1'b0 || a_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ena_hold%0d: out=%h flag=%b last=%b ready=%b, required 3 1 0 0",
                         i, a_out, a_flag, a_last, a_ready);
            end
        end
        step_a(1'b0, 16'h0000, 1'b1);
        checks++;
        if (a_out !== 4'h4 || a_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ena_resume: out=%h last=%b, required 4 1", a_out, a_last);
        end
        step_a(1'b0, 16'h0000, 1'b1);
        checks++;
        if (a_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ena_end: flag=%b, required 0", a_flag);
        end
    endtask

    task automatic test_reset_pending();
        step_a(1'b1, 16'h1234, 1'b1);
        step_a(1'b1, 16'h5678, 1'b1);
        step_a(1'b0, 16'h0000, 1'b1);
        pulse_reset();
        #1;
        checks++;
        if (a_flag !== 1'b0 || a_last !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid: flag=%b last=%b ready=%b, required 0 0 1", a_flag, a_last, a_ready);
        end
        for (int i = 0; i < 8; i++) begin
            step_a(1'b0, 16'h0000, 1'b1);
            checks++;
            if (a_flag !== 1'b0 || a_out !== 4'h0) begin
                errors++;
                $display("[TB] FAIL reset_drop%0d: flag=%b out=%h, required 0 0", i, a_flag, a_out);
            end
        end
    endtask

    task automatic test_last_edge_accept();
        logic [3:0] exp_out [4];
        exp_out = '{4'h9, 4'hA, 4'hB, 4'hC};
        step_a(1'b1, 16'h1234, 1'b1);
        for (int i = 0; i < 3; i++) step_a(1'b0, 16'h0000, 1'b1);
        checks++;
        if (a_out !== 4'h4 || a_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lastacc_pre: out=%h last=%b, required 4 1", a_out, a_last);
        end
        for (int i = 0; i < 4; i++) begin
            step_a(i == 0, 16'h9ABC, 1'b1);
            checks++;
            if (a_out !== exp_out[i] || a_flag !== 1'b1 || a_ready !== 1'b1 || a_last !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL lastacc_beat%0d: out=%h flag=%b ready=%b last=%b, required %h 1 1 %b",
                         i, a_out, a_flag, a_ready, a_last, exp_out[i], (i == 3));
            end
        end
        step_a(1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_random();
        logic        ld, en;
        logic [15:0] d;
        logic [3:0]  exp_out;
        bit          exp_last;
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 99) < 55);
            en = ($urandom_range(0, 99) < 85);
            d  = 16'($urandom);
            step_a(ld, d, en);
            exp_out  = m_active ? msb_beat(m_frame, m_idx) : 4'h0;
            exp_last = m_active && (m_idx == 3);
            checks++;
            if (a_out !== exp_out || a_flag !== m_active || a_last !== exp_last || a_ready !== (en && !m_pend_v)) begin
                errors++;
                $display("[TB] FAIL random%0d: out=%h flag=%b last=%b ready=%b, required %h %b %b %b",
                         i, a_out, a_flag, a_last, a_ready, exp_out, m_active, exp_last, (en && !m_pend_v));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0;
        a_load = 1'b0; a_data = '0;
        b_load = 1'b0; b_data = '0;
        c_load = 1'b0; c_data = '0;
        model_reset();
        test_reset();
        test_wide_single_lane();
        test_lsb_lanes();
        test_back_to_back();
        test_ena_hold();
        test_reset_pending();
        test_last_edge_accept();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
